// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath constants and types. The assembler uses them here, and
// the block-to-state splitter downstream uses them too.
//   AES_BLOCK_W : plaintext block width (128)
//   AES_WORD_W  : stream word width (32)
//   AES_NB      : words per block (4)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_NB      = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

endpackage

// File: rtl/aes_block_assembler.sv
// -----------------------------------------------------------------------------
// aes_block_assembler
// Packs a valid/ready stream of WORD_W-bit words into N_WORDS-word blocks.
// The first word of a block lands in the most significant position. Each
// completed block is presented on a registered valid/ready output. The design
// sustains one block every N_WORDS input cycles, with no bubbles.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_word    : input word
//   in_valid   : in_word valid
//   in_ready   : assembler accepts in_word this cycle (combinational)
//   in_last    : final word of a message (only used with AES_ASM_ZERO_PAD_EN)
//   out_block  : assembled block, big-endian word order
//   out_valid  : out_block valid
//   out_ready  : downstream accepts out_block
//   blk_cnt    : blocks delivered since reset, wraps modulo 2^16
//
// Configuration macro
//   AES_ASM_ZERO_PAD_EN : when this is defined, a transfer with in_last=1
//                         completes the block at once. The remaining word
//                         positions are zero-filled.
// -----------------------------------------------------------------------------
module aes_block_assembler
    import aes_pkg::*;
#(
    parameter int WORD_W  = AES_WORD_W,
    parameter int N_WORDS = AES_NB
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           in_word,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    output logic [WORD_W*N_WORDS-1:0]   out_block,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [15:0]                 blk_cnt
);

    localparam int BLOCK_W = WORD_W * N_WORDS;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    logic [BLOCK_W-1:0] r_asm;
    logic [CNT_W-1:0]   r_cnt;
    logic [BLOCK_W-1:0] r_out_block;
    logic               r_out_valid;
    logic [15:0]        r_blk_cnt;

    logic               w_completing;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [BLOCK_W-1:0] w_full;

`ifdef AES_ASM_ZERO_PAD_EN
    assign w_completing = (r_cnt == LAST_IDX) || in_last;
`else
    assign w_completing = (r_cnt == LAST_IDX);
    // in_last has no function in this build.
    logic w_unused;
    assign w_unused = in_last;
`endif

    // Only the completing word stalls. It waits while the previous block is
    // still held and is not being taken this cycle.
    assign in_ready   = !(w_completing && r_out_valid && !out_ready);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // The completed block is made from the held words, the current word in
    // slot r_cnt, and (with zero padding) zeros in the later slots.
    generate
        for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_slot
            localparam logic [CNT_W-1:0] K = CNT_W'(gi);
            localparam int HI = BLOCK_W - 1 - gi * WORD_W;

`ifdef AES_ASM_ZERO_PAD_EN
            assign w_full[HI -: WORD_W] = (r_cnt == K) ? in_word :
                                          (r_cnt >  K) ? r_asm[HI -: WORD_W] :
                                                         '0;
`else
            assign w_full[HI -: WORD_W] = (r_cnt == K) ? in_word :
                                                         r_asm[HI -: WORD_W];
`endif

            // Each slot captures only its own word. Unwritten slots keep
            // stale data, which is never exposed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_asm[HI -: WORD_W] <= '0;
                end else if (w_in_xfer && (r_cnt == K)) begin
                    r_asm[HI -: WORD_W] <= in_word;
                end
            end
        end
    endgenerate

    // Word counter together with the output register: FILL_k / HOLD implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_out_block <= '0;
            r_out_valid <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_cnt <= w_completing ? '0 : r_cnt + 1'b1;
            end

            // A load wins over a clear, so back-to-back blocks leave no gap.
            if (w_in_xfer && w_completing) begin
                r_out_block <= w_full;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_xfer) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    assign out_block = r_out_block;
    assign out_valid = r_out_valid;
    assign blk_cnt   = r_blk_cnt;

endmodule
